// File: rtl/ebus_ctl.sv
// EBUS master controller: arbitrates CPU-PI and front-end requests and runs one
// EBUS transfer at a time. Define EBUS_CTL_TIMEOUT_EN to add the DEMAND/RELEASE abort timer.
module ebus_ctl #(
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pi_req,
   input  logic        pi_write,
   input  logic [6:0]  pi_cs,
   input  logic [2:0]  pi_func,
   input  logic [35:0] pi_wdata,
   output logic        pi_done,
   input  logic        fe_req,
   input  logic        fe_write,
   input  logic [6:0]  fe_cs,
   input  logic [2:0]  fe_func,
   input  logic [35:0] fe_wdata,
   output logic        fe_done,
   output logic [35:0] rd_data,
   output logic        err,
   output logic [6:0]  ebus_cs,
   output logic [2:0]  ebus_func,
   output logic        ebus_demand,
   output logic        ebus_drive,
   output logic [35:0] ebus_wdata,
   input  logic        ebus_xfer,
   input  logic [35:0] ebus_rdata,
   output logic        busy
);

   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
      $error("ebus_ctl: SETUP_CYCLES out of range 1..15");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("ebus_ctl: TIMEOUT_CYCLES out of range 2..255");
   end

   typedef enum logic [2:0] {IDLE, SETUP, DEMAND, RELEASE, DONE} state_t;

   localparam logic [3:0] SLAST = 4'(SETUP_CYCLES - 1);

   state_t      state, state_nxt;
   logic        last_fe, gnt_fe, grant, grant_fe, capture, active;
   logic [3:0]  scnt;
   logic        lat_write;
   logic [6:0]  lat_cs;
   logic [2:0]  lat_func;
   logic [35:0] lat_wdata;
`ifdef EBUS_CTL_TIMEOUT_EN
   localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]  tcnt;
   logic        tmo_hit, abort, err_q;
`endif

   // On a tie the requester that did not win last time gets the bus
   assign grant_fe = fe_req && (!pi_req || !last_fe);

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      capture   = 1'b0;
`ifdef EBUS_CTL_TIMEOUT_EN
      abort     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pi_req || fe_req) begin
               grant     = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (scnt == SLAST) state_nxt = DEMAND;
         end
         DEMAND: begin
            if (ebus_xfer) begin
               capture   = !lat_write;
               state_nxt = RELEASE;
            end
`ifdef EBUS_CTL_TIMEOUT_EN
            else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = DONE;
            end
`endif
         end
         RELEASE: begin
            if (!ebus_xfer) state_nxt = DONE;
`ifdef EBUS_CTL_TIMEOUT_EN
            else if (tmo_hit) begin
               abort     = 1'b1;
               state_nxt = DONE;
            end
`endif
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_fe <= 1'b1;
         gnt_fe  <= 1'b0;
         scnt    <= '0;
         rd_data <= '0;
      end else begin
         if (grant) begin
            last_fe <= grant_fe;
            gnt_fe  <= grant_fe;
            scnt    <= '0;
         end else if (state == SETUP) begin
            scnt <= scnt + 4'd1;
         end
         if (capture) rd_data <= ebus_rdata;
      end
   end

   // Operands are frozen at grant so requester changes cannot disturb the bus
   always_ff @(posedge clk) begin
      if (grant) begin
         lat_write <= grant_fe ? fe_write : pi_write;
         lat_cs    <= grant_fe ? fe_cs    : pi_cs;
         lat_func  <= grant_fe ? fe_func  : pi_func;
         lat_wdata <= grant_fe ? fe_wdata : pi_wdata;
      end
   end

`ifdef EBUS_CTL_TIMEOUT_EN
   assign tmo_hit = (tcnt == TLAST);
   assign err     = err_q;

   // Restarts on every state change, so it times DEMAND and RELEASE separately
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         tcnt <= (state_nxt != state) ? 8'd0 : tcnt + 8'd1;
         if (grant)      err_q <= 1'b0;
         else if (abort) err_q <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   assign active      = (state == SETUP) || (state == DEMAND) || (state == RELEASE);
   assign ebus_cs     = active ? lat_cs : '0;
   assign ebus_func   = active ? lat_func : '0;
   assign ebus_drive  = active && lat_write;
   assign ebus_wdata  = (active && lat_write) ? lat_wdata : '0;
   assign ebus_demand = (state == DEMAND);
   assign pi_done     = (state == DONE) && !gnt_fe;
   assign fe_done     = (state == DONE) && gnt_fe;
   assign busy        = (state != IDLE);

endmodule
